// File: rtl/rd_ctrl_gray_if.sv
// Bus between the FIFO read controller and its consumer, memory and write controller.
// RD_CTRL_UNDERFLOW_EN adds the underflow_o pulse.
interface rd_ctrl_gray_if #(
    parameter int ADDR_W = 4
);
    logic              rd_en_i;
    logic [ADDR_W:0]   wr_ptr_gray_i;
    logic              rd_en_o;
    logic [ADDR_W-1:0] rd_addr_o;
    logic [ADDR_W:0]   rd_ptr_gray_o;
    logic              fifo_empty_o;
    logic              almost_empty_o;
    logic [ADDR_W:0]   rd_level_o;
`ifdef RD_CTRL_UNDERFLOW_EN
    logic              underflow_o;

    modport slave (
        input  rd_en_i, wr_ptr_gray_i,
        output rd_en_o, rd_addr_o, rd_ptr_gray_o, fifo_empty_o,
               almost_empty_o, rd_level_o, underflow_o
    );

    modport master (
        output rd_en_i, wr_ptr_gray_i,
        input  rd_en_o, rd_addr_o, rd_ptr_gray_o, fifo_empty_o,
               almost_empty_o, rd_level_o, underflow_o
    );
`else
    modport slave (
        input  rd_en_i, wr_ptr_gray_i,
        output rd_en_o, rd_addr_o, rd_ptr_gray_o, fifo_empty_o,
               almost_empty_o, rd_level_o
    );

    modport master (
        output rd_en_i, wr_ptr_gray_i,
        input  rd_en_o, rd_addr_o, rd_ptr_gray_o, fifo_empty_o,
               almost_empty_o, rd_level_o
    );
`endif
endinterface

// File: rtl/rd_ctrl_gray.sv
// Read-side controller of the async FIFO: write-pointer synchroniser, read pointers, flags, level.
// Optional feature macro: RD_CTRL_UNDERFLOW_EN (adds the registered underflow_o pulse).
module rd_ctrl_gray #(
    parameter int ADDR_W        = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int AEMPTY_THRESH = 2
) (
    input logic          clk_i,
    input logic          rst_n,
    rd_ctrl_gray_if.slave bus
);
    logic [ADDR_W:0] sync_q [SYNC_STAGES];
    logic [ADDR_W:0] sync_d [SYNC_STAGES];
    logic [ADDR_W:0] wq_gray;
    logic [ADDR_W:0] wq_bin;

    logic [ADDR_W:0] rd_bin_q, rd_bin_d;
    logic [ADDR_W:0] rd_gray_q, rd_gray_d;
    logic            empty_q, empty_d;
    logic            aempty_q, aempty_d;
    logic [ADDR_W:0] level_q, level_d;
    logic            rd_en;

    always_comb begin
        sync_d[0] = bus.wr_ptr_gray_i;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign wq_gray = sync_q[SYNC_STAGES-1];

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        wq_bin = '0;
        for (int i = 0; i <= ADDR_W; i++) begin
            wq_bin[i] = ^(wq_gray >> i);
        end
    end

    assign rd_en = bus.rd_en_i & ~empty_q;

    // Flags are computed from the look-ahead pointer so the emptying read flags on its own edge.
    always_comb begin
        rd_bin_d  = rd_bin_q + (ADDR_W+1)'(rd_en);
        rd_gray_d = rd_bin_d ^ (rd_bin_d >> 1);
        empty_d   = (rd_gray_d == wq_gray);
        level_d   = wq_bin - rd_bin_d;
        aempty_d  = (level_d <= (ADDR_W+1)'(AEMPTY_THRESH));
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            rd_bin_q  <= '0;
            rd_gray_q <= '0;
            empty_q   <= 1'b1;
            aempty_q  <= 1'b1;
            level_q   <= '0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            rd_bin_q  <= rd_bin_d;
            rd_gray_q <= rd_gray_d;
            empty_q   <= empty_d;
            aempty_q  <= aempty_d;
            level_q   <= level_d;
        end
    end

    assign bus.rd_en_o        = rd_en;
    assign bus.rd_addr_o      = rd_bin_q[ADDR_W-1:0];
    assign bus.rd_ptr_gray_o  = rd_gray_q;
    assign bus.fifo_empty_o   = empty_q;
    assign bus.almost_empty_o = aempty_q;
    assign bus.rd_level_o     = level_q;

`ifdef RD_CTRL_UNDERFLOW_EN
    logic underflow_q, underflow_d;

    assign underflow_d = bus.rd_en_i & empty_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            underflow_q <= 1'b0;
        end else begin
            underflow_q <= underflow_d;
        end
    end

    assign bus.underflow_o = underflow_q;
`endif
endmodule

// File: tb/tb_rd_ctrl_gray.sv
// Self-checking bench for rd_ctrl_gray: vector table, directed corner sequences, random vs. model.
// Underflow checks are compiled only when RD_CTRL_UNDERFLOW_EN is defined.
module tb_rd_ctrl_gray;
    localparam int ADDR_W = 4;
    localparam int SYNC   = 2;
    localparam int PTR_M  = 32;

    logic clk;
    logic rst_n;
    int   check_cnt = 0;
    int   pass_cnt  = 0;

    rd_ctrl_gray_if #(.ADDR_W(ADDR_W)) bus ();

    rd_ctrl_gray #(.ADDR_W(ADDR_W), .SYNC_STAGES(SYNC), .AEMPTY_THRESH(2)) dut (
        .clk_i (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rd_en;
        logic [4:0] wr_gray;
        logic       exp_rd_en;
        logic       exp_empty;
        logic [4:0] exp_level;
        logic       exp_aempty;
        logic [4:0] exp_ptr;
    } vec_t;

    vec_t vecs[17];

    // Reference state: plain integer pointers and a history of written values
    int  rd_m;
    int  wr_m;
    int  hist_m[SYNC];
    int  level_m;
    bit  empty_m;

    function automatic logic [4:0] gray5(input int b);
        logic [4:0] v;
        v = 5'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_cnt++;
        if (actual === expected) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rd_en, input logic [4:0] wr_gray);
        @(negedge clk);
        bus.rd_en_i       = rd_en;
        bus.wr_ptr_gray_i = wr_gray;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n             = 1'b0;
        bus.rd_en_i       = 1'b0;
        bus.wr_ptr_gray_i = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd_m    = 0;
        wr_m    = 0;
        level_m = 0;
        empty_m = 1'b1;
        for (int i = 0; i < SYNC; i++) hist_m[i] = 0;
    endtask

    task automatic idle(input int n, input logic [4:0] wr_gray);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, wr_gray);
    endtask

    task automatic readN(input int n, input logic [4:0] wr_gray);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, wr_gray);
        applyStimulus(1'b0, wr_gray);
    endtask

    initial begin
        rst_n             = 1'b1;
        bus.rd_en_i       = 1'b0;
        bus.wr_ptr_gray_i = '0;

        // ---------- Reset mid-run with a non-zero level ----------
        doReset();
        idle(4, gray5(5));
        @(negedge clk);
        checkOutput("pre_reset_level", 32'(bus.rd_level_o), 32'd5);
        bus.rd_en_i = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_empty", 32'(bus.fifo_empty_o), 32'd1);
        checkOutput("rst_aempty", 32'(bus.almost_empty_o), 32'd1);
        checkOutput("rst_level", 32'(bus.rd_level_o), 32'd0);
        checkOutput("rst_ptr", 32'(bus.rd_ptr_gray_o), 32'd0);
        checkOutput("rst_addr", 32'(bus.rd_addr_o), 32'd0);
        checkOutput("rst_rd_en_o", 32'(bus.rd_en_o), 32'd0);

        // ---------- Vector table: sync latency, drain, simultaneous events ----------
        vecs[0]  = '{1'b0, 5'b00001, 1'b0, 1'b1, 5'd0, 1'b1, 5'b00000};
        vecs[1]  = '{1'b0, 5'b00001, 1'b0, 1'b1, 5'd0, 1'b1, 5'b00000};
        vecs[2]  = '{1'b0, 5'b00001, 1'b0, 1'b0, 5'd1, 1'b1, 5'b00000};
        vecs[3]  = '{1'b0, 5'b00010, 1'b0, 1'b0, 5'd1, 1'b1, 5'b00000};
        vecs[4]  = '{1'b0, 5'b00010, 1'b0, 1'b0, 5'd1, 1'b1, 5'b00000};
        vecs[5]  = '{1'b0, 5'b00010, 1'b0, 1'b0, 5'd3, 1'b0, 5'b00000};
        vecs[6]  = '{1'b1, 5'b00010, 1'b1, 1'b0, 5'd2, 1'b1, 5'b00001};
        vecs[7]  = '{1'b1, 5'b00010, 1'b1, 1'b0, 5'd1, 1'b1, 5'b00011};
        vecs[8]  = '{1'b1, 5'b00010, 1'b1, 1'b1, 5'd0, 1'b1, 5'b00010};
        vecs[9]  = '{1'b1, 5'b00010, 1'b0, 1'b1, 5'd0, 1'b1, 5'b00010};
        vecs[10] = '{1'b0, 5'b00110, 1'b0, 1'b1, 5'd0, 1'b1, 5'b00010};
        vecs[11] = '{1'b0, 5'b00110, 1'b0, 1'b1, 5'd0, 1'b1, 5'b00010};
        vecs[12] = '{1'b0, 5'b00110, 1'b0, 1'b0, 5'd1, 1'b1, 5'b00010};
        vecs[13] = '{1'b0, 5'b00111, 1'b0, 1'b0, 5'd1, 1'b1, 5'b00010};
        vecs[14] = '{1'b0, 5'b00111, 1'b0, 1'b0, 5'd1, 1'b1, 5'b00010};
        vecs[15] = '{1'b1, 5'b00111, 1'b1, 1'b0, 5'd1, 1'b1, 5'b00110};
        vecs[16] = '{1'b0, 5'b00111, 1'b0, 1'b0, 5'd1, 1'b1, 5'b00110};

        doReset();
        for (int v = 0; v < 17; v++) begin
            applyStimulus(vecs[v].rd_en, vecs[v].wr_gray);
            #1;
            checkOutput($sformatf("vec%0d_rd_en_o", v), 32'(bus.rd_en_o), 32'(vecs[v].exp_rd_en));
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d_empty", v), 32'(bus.fifo_empty_o), 32'(vecs[v].exp_empty));
            checkOutput($sformatf("vec%0d_level", v), 32'(bus.rd_level_o), 32'(vecs[v].exp_level));
            checkOutput($sformatf("vec%0d_aempty", v), 32'(bus.almost_empty_o), 32'(vecs[v].exp_aempty));
            checkOutput($sformatf("vec%0d_ptr", v), 32'(bus.rd_ptr_gray_o), 32'(vecs[v].exp_ptr));
        end

        // ---------- Full drain of 16 entries ----------
        doReset();
        idle(3, 5'b11000);
        @(negedge clk);
        checkOutput("drain_level16", 32'(bus.rd_level_o), 32'd16);
        for (int k = 0; k < 16; k++) begin
            bus.rd_en_i = 1'b1;
            #1;
            checkOutput($sformatf("drain_addr%0d", k), 32'(bus.rd_addr_o), 32'(k));
            checkOutput($sformatf("drain_en%0d", k), 32'(bus.rd_en_o), 32'd1);
            @(posedge clk);
            #1;
            checkOutput($sformatf("drain_ptr%0d", k), 32'(bus.rd_ptr_gray_o), 32'(gray5(k + 1)));
            checkOutput($sformatf("drain_empty%0d", k), 32'(bus.fifo_empty_o), 32'(k == 15));
            @(negedge clk);
        end
        #1;
        checkOutput("drain_ptr_final", 32'(bus.rd_ptr_gray_o), 32'b11000);
        checkOutput("drain_en_after", 32'(bus.rd_en_o), 32'd0);

        // ---------- Wrap from 30 through 31, 0, 1 ----------
        doReset();
        idle(3, gray5(16));
        readN(16, gray5(16));
        idle(3, gray5(30));
        readN(14, gray5(30));
        idle(4, gray5(1));
        @(negedge clk);
        checkOutput("wrap_addr_start", 32'(bus.rd_addr_o), 32'd14);
        checkOutput("wrap_level", 32'(bus.rd_level_o), 32'd3);
        for (int k = 0; k < 3; k++) begin
            bus.rd_en_i = 1'b1;
            #1;
            checkOutput($sformatf("wrap_addr%0d", k), 32'(bus.rd_addr_o), 32'((14 + k) % 16));
            @(negedge clk);
        end
        bus.rd_en_i = 1'b0;
        #1;
        checkOutput("wrap_empty", 32'(bus.fifo_empty_o), 32'd1);
        checkOutput("wrap_ptr", 32'(bus.rd_ptr_gray_o), 32'b00001);
        checkOutput("wrap_rd_en_o", 32'(bus.rd_en_o), 32'd0);

`ifdef RD_CTRL_UNDERFLOW_EN
        // ---------- Underflow pulse ----------
        doReset();
        applyStimulus(1'b1, 5'b00000);
        #1;
        checkOutput("uf_rd_en_o", 32'(bus.rd_en_o), 32'd0);
        checkOutput("uf_before", 32'(bus.underflow_o), 32'd0);
        applyStimulus(1'b0, 5'b00000);
        #1;
        checkOutput("uf_pulse", 32'(bus.underflow_o), 32'd1);
        checkOutput("uf_ptr", 32'(bus.rd_ptr_gray_o), 32'd0);
        applyStimulus(1'b0, 5'b00000);
        #1;
        checkOutput("uf_cleared", 32'(bus.underflow_o), 32'd0);
`endif

        // ---------- Random traffic against the reference model ----------
        doReset();
        for (int c = 0; c < 600; c++) begin
            logic rd_req;
            logic exp_en;
            int   lvl_now;
            rd_req  = ($urandom_range(0, 99) < 55);
            lvl_now = (wr_m - rd_m + PTR_M) % PTR_M;
            if ($urandom_range(0, 99) < 50 && lvl_now < 16) wr_m = (wr_m + 1) % PTR_M;
            applyStimulus(rd_req, gray5(wr_m));
            exp_en = rd_req && !empty_m;
            #1;
            checkOutput("rnd_rd_en_o", 32'(bus.rd_en_o), 32'(exp_en));
            @(posedge clk);
            if (exp_en) rd_m = (rd_m + 1) % PTR_M;
            level_m = (hist_m[SYNC-1] - rd_m + PTR_M) % PTR_M;
            empty_m = (level_m == 0);
            for (int s = SYNC - 1; s > 0; s--) hist_m[s] = hist_m[s-1];
            hist_m[0] = wr_m;
            #1;
            checkOutput("rnd_level", 32'(bus.rd_level_o), 32'(level_m));
            checkOutput("rnd_empty", 32'(bus.fifo_empty_o), 32'(empty_m));
            checkOutput("rnd_aempty", 32'(bus.almost_empty_o), 32'(level_m <= 2));
            checkOutput("rnd_addr", 32'(bus.rd_addr_o), 32'(rd_m % 16));
            checkOutput("rnd_ptr", 32'(bus.rd_ptr_gray_o), 32'(gray5(rd_m)));
        end

        $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
